instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage for the single-cycle MIPS datapath.
- Holds the PC and fetches one instruction per step from instruction memory over a ready-handshake. It presents the instruction to decode/control (opcode = instr[31:26]).
- After the datapath signals completion, it updates the PC from the Jump/Branch/Zero results produced downstream.
- Provides a retired-instruction counter for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word-aligned).
- ADDR_W, 32, PC / memory address width; fixed 32 for MIPS, kept only for documentation.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request, high in FETCH state
- imem_addr  out  32  byte address of requested word (= pc)
- imem_ready  in  1  memory has valid imem_rdata this cycle; only sampled while imem_req=1
- imem_rdata  in  32  instruction word
- instr  out  32  latched instruction, stable while instr_valid=1
- instr_valid  out  1  instr is valid and being executed
- pc  out  32  current PC
- pc_plus4  out  32  pc + 4, modulo 2^32
- exec_done  in  1  datapath finished current instruction; ignored unless instr_valid=1
- branch  in  1  Branch from control
- jump  in  1  Jump from control
- zero  in  1  ALU Zero flag
- branch_offset  in  32  sign-extended immediate (not yet shifted)
- jump_index  in  26  instr[25:0] jump field
- retired_count  out  32  number of completed instructions, wraps

Behaviour:
- States: FETCH, ISSUE. Moore outputs: imem_req = (state==FETCH); instr_valid = (state==ISSUE).
- Reset (reset=1 at an edge, any state, mid-fetch included):
  - state<=FETCH, pc<=RESET_PC, instr<=0, retired_count<=0.
  - imem_ready/exec_done in a reset cycle are ignored.
  - First request is issued in the first cycle after reset deasserts.
- FETCH:
  - imem_addr=pc.
  - If imem_ready=1: instr<=imem_rdata, state<=ISSUE.
  - Else stay; pc and imem_addr held constant (request must remain stable until accepted).
- ISSUE:
  - instr held constant.
  - If exec_done=1: pc<=next_pc, retired_count<=retired_count+1, state<=FETCH.
  - Else stay indefinitely.
- next_pc (combinational, evaluated in the exec_done cycle), in priority order:
  - jump=1: {pc_plus4[31:28], jump_index, 2'b00}
  - else branch=1 and zero=1: pc_plus4 + (branch_offset << 2), 32-bit wrap, carry discarded
  - else pc_plus4
- Jump takes priority over branch if both are asserted (illegal from control, but defined).
- Minimum throughput: 2 cycles/instruction with zero-wait memory (ready in first FETCH cycle).
- Wrap-around:
  - pc=32'hFFFF_FFFC sequential -> 32'h0000_0000.
  - retired_count 32'hFFFF_FFFF + 1 -> 0.
- pc[1:0] is always 00 by construction; no misalignment detection.
- branch/jump/zero/branch_offset/jump_index are don't-care outside the ISSUE+exec_done cycle.

Decomposition:
- Shared package mips_pkg holds:
  - Opcode constants: OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_J=6'b000010.
  - Fetch state enum {FETCH, ISSUE}.
  - Constant RESET_PC default.
- Sub-module next_pc_calc (combinational: pc_plus4, branch, jump, zero, branch_offset, jump_index -> next_pc), reused by any future pipelined version.

Test Plan:
- Reset/first fetch:
  - Stimulus: reset 2 cycles, then release, imem_ready=1 with rdata=32'h8C01_0004.
  - Response: cycle after release imem_req=1, imem_addr=0. Next cycle instr_valid=1, instr=32'h8C01_0004.
- Sequential flow and wait states:
  - Stimulus: imem_ready low 3 cycles; exec_done with branch=jump=0.
  - Response: imem_addr stays 0 during the 3 waits. After exec_done, pc=4 and retired_count=1.
- Taken/not-taken beq:
  - Stimulus: pc=0x10, branch=1, offset=32'hFFFF_FFFE.
  - Response: zero=1 gives pc=0x0C; zero=0 gives pc=0x14.
- Jump:
  - Stimulus: pc=0x4000_0020, jump=1, jump_index=26'h000_0040, branch=1, zero=1.
  - Response: pc=0x4000_0100 (jump wins over branch).
- Reset mid-operation:
  - Stimulus: assert reset in ISSUE with exec_done=1 and pc=0x24, retired_count=5.
  - Response: next cycle pc=RESET_PC, retired_count=0, state FETCH, no increment.
- Wrap:
  - Stimulus: pc=0xFFFF_FFFC, sequential exec_done.
  - Response: pc=0x0000_0000, imem_addr=0 in the following FETCH.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the fetch stage and its neighbours.
//   - primary opcode constants (instr[31:26])
//   - fetch FSM state encoding
//   - default reset PC
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/ready bus.
//   imem_req   : fetch request (master -> memory)
//   imem_addr  : byte address of requested word (master -> memory)
//   imem_ready : imem_rdata valid this cycle (memory -> master)
//   imem_rdata : instruction word (memory -> master)
interface instr_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Next-PC selection for a MIPS fetch stage (purely combinational).
//   pc_plus4      : address of the sequential successor
//   branch/zero   : beq taken when both set
//   jump          : j-type, highest priority
//   branch_offset : sign-extended word offset (shifted here)
//   jump_index    : instr[25:0]
//   next_pc       : selected next PC
module next_pc_calc (
    input  logic [31:0] pc_plus4,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_index,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], jump_index, 2'b00};
        end else if (branch && zero) begin
            // offset bits [31:30] fall off the shift; the sum wraps mod 2^32
            next_pc = pc_plus4 + (branch_offset << 2);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage for the single-cycle MIPS datapath.
// Holds the PC, fetches one word per step over the imem bus, presents it to
// decode until the datapath reports completion, then advances the PC.
//   clk, reset     : clock, synchronous active-high reset
//   imem           : instruction-memory bus (master side)
//   instr          : latched instruction, valid while instr_valid
//   instr_valid    : instruction is being executed
//   pc, pc_plus4   : current PC and its sequential successor
//   exec_done      : datapath finished current instruction
//   branch, jump, zero, branch_offset, jump_index : next-PC controls
//   retired_count  : completed instructions, wraps
//
// state | meaning
// FETCH | request pc from imem until imem_ready
// ISSUE | instr held for execute until exec_done
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    instr_fetch_unit_if.master imem,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              exec_done,
    input  logic              branch,
    input  logic              jump,
    input  logic              zero,
    input  logic [31:0]       branch_offset,
    input  logic [25:0]       jump_index,
    output logic [31:0]       retired_count
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  retired_q;
    logic         req_q;
    logic         valid_q;
    logic [31:0]  pc_plus4_w;
    logic [31:0]  next_pc_d;

    assign pc_plus4_w = pc_q + 32'd4;

    next_pc_calc u_next_pc_calc (
        .pc_plus4      (pc_plus4_w),
        .branch        (branch),
        .jump          (jump),
        .zero          (zero),
        .branch_offset (branch_offset),
        .jump_index    (jump_index),
        .next_pc       (next_pc_d)
    );

    // req_q/valid_q track state_q so the Moore outputs come straight from flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
            req_q     <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem.imem_ready) begin
                        instr_q <= imem.imem_rdata;
                        state_q <= ISSUE;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (exec_done) begin
                        pc_q      <= next_pc_d;
                        retired_q <= retired_q + 32'd1;
                        state_q   <= FETCH;
                        req_q     <= 1'b1;
                        valid_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = valid_q;
    assign pc             = pc_q;
    assign pc_plus4       = pc_plus4_w;
    assign retired_count  = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        exec_done;
    logic        branch;
    logic        jump;
    logic        zero;
    logic [31:0] branch_offset;
    logic [25:0] jump_index;
    logic [31:0] retired_count;

    instr_fetch_unit_if imem_bus ();

    instr_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .imem          (imem_bus),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .exec_done     (exec_done),
        .branch        (branch),
        .jump          (jump),
        .zero          (zero),
        .branch_offset (branch_offset),
        .jump_index    (jump_index),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        int          wait_cyc;
        int          exec_wait;
        logic        br;
        logic        jp;
        logic        z;
        logic [31:0] off;
        logic [25:0] jidx;
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] sb_q [$];
    int          n_total = 0;
    int          n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic br, input logic jp, input logic z,
                            input logic [31:0] off, input logic [25:0] jidx);
        branch        = br;
        jump          = jp;
        zero          = z;
        branch_offset = off;
        jump_index    = jidx;
    endtask

    // One fetch + execute step; the memory side pushes the word it returns
    // into the scoreboard, the decode side pops it when instr_valid rises.
    task automatic run_instr(input vec_t v, input logic [31:0] exp_ret);
        logic [31:0] exp_w;
        chk("fetch_req", {31'd0, imem_bus.imem_req}, 32'd1);
        chk("fetch_addr", imem_bus.imem_addr, v.exp_pc);
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = 32'hBAD0_BAD0;
        for (int w = 0; w < v.wait_cyc; w++) begin
            tick();
            chk("wait_addr", imem_bus.imem_addr, v.exp_pc);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = v.word;
        sb_q.push_back(v.word);
        tick();
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = 32'hBAD1_BAD1;
        chk("issue_valid", {31'd0, instr_valid}, 32'd1);
        chk("issue_req", {31'd0, imem_bus.imem_req}, 32'd0);
        if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            exp_w = sb_q.pop_front();
            chk("issue_instr", instr, exp_w);
        end
        // control inputs are don't-care until the exec_done cycle
        set_ctrl(~v.br, ~v.jp, ~v.z, ~v.off, ~v.jidx);
        for (int e = 0; e < v.exec_wait; e++) begin
            tick();
            chk("hold_instr", instr, v.word);
            chk("hold_pc", pc, v.exp_pc);
        end
        set_ctrl(v.br, v.jp, v.z, v.off, v.jidx);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        chk("next_pc", pc, v.exp_next);
        chk("retired", retired_count, exp_ret);
        chk("back_fetch", {31'd0, imem_bus.imem_req}, 32'd1);
    endtask

    task automatic seq_vec(input logic [31:0] p, output vec_t v);
        v = '{word: 32'h0000_0020, wait_cyc: 0, exec_wait: 0, br: 1'b0, jp: 1'b0, z: 1'b0,
              off: 32'd0, jidx: 26'd0, exp_pc: p, exp_next: p + 32'd4};
    endtask

    initial begin
        vec_t v;
        tbl[0]  = '{32'h8C01_0004, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,         26'h0,  32'h0000_0000, 32'h0000_0004};
        tbl[1]  = '{32'h0022_1820, 3, 2, 1'b0, 1'b0, 1'b0, 32'h0,         26'h0,  32'h0000_0004, 32'h0000_0008};
        tbl[2]  = '{32'h1022_0003, 1, 0, 1'b1, 1'b0, 1'b0, 32'h3,         26'h0,  32'h0000_0008, 32'h0000_000C};
        tbl[3]  = '{32'hAC03_0008, 0, 1, 1'b0, 1'b0, 1'b0, 32'h0,         26'h0,  32'h0000_000C, 32'h0000_0010};
        tbl[4]  = '{32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 26'h0,  32'h0000_0010, 32'h0000_000C};
        tbl[5]  = '{32'h0000_0000, 2, 0, 1'b0, 1'b0, 1'b0, 32'h0,         26'h0,  32'h0000_000C, 32'h0000_0010};
        tbl[6]  = '{32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 26'h0,  32'h0000_0010, 32'h0000_0014};
        tbl[7]  = '{32'h1000_0002, 0, 0, 1'b1, 1'b0, 1'b1, 32'h1000_0002, 26'h0,  32'h0000_0014, 32'h4000_0020};
        tbl[8]  = '{32'h0800_0040, 0, 0, 1'b1, 1'b1, 1'b1, 32'h0000_0005, 26'h40, 32'h4000_0020, 32'h4000_0100};
        tbl[9]  = '{32'h1000_FFBE, 1, 0, 1'b1, 1'b0, 1'b1, 32'h2FFF_FFBE, 26'h0,  32'h4000_0100, 32'hFFFF_FFFC};
        tbl[10] = '{32'h0123_4567, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,         26'h0,  32'hFFFF_FFFC, 32'h0000_0000};
        tbl[11] = '{32'h89AB_CDEF, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,         26'h0,  32'h0000_0000, 32'h0000_0004};

        reset = 1'b1;
        exec_done = 1'b1;
        set_ctrl(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_retired", retired_count, 32'h0);
        chk("rst_req", {31'd0, imem_bus.imem_req}, 32'd1);
        reset = 1'b0;
        exec_done = 1'b0;
        imem_bus.imem_ready = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_instr(tbl[i], 32'(i + 1));
            if (i == 9) chk("pc_plus4_wrap", pc_plus4, 32'h0000_0000);
        end

        // Reset in ISSUE with exec_done high: pc=0x24, retired=5
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seq_vec(32'(i * 4), v);
            run_instr(v, 32'(i + 1));
        end
        seq_vec(32'h10, v);
        v.br = 1'b1; v.z = 1'b1; v.off = 32'h4; v.exp_next = 32'h24;
        run_instr(v, 32'd5);
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'h0800_0000;
        tick();
        imem_bus.imem_ready = 1'b0;
        chk("mid_valid", {31'd0, instr_valid}, 32'd1);
        chk("mid_pc", pc, 32'h24);
        chk("mid_retired", retired_count, 32'd5);
        set_ctrl(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
        exec_done = 1'b1;
        reset = 1'b1;
        tick();
        exec_done = 1'b0;
        reset = 1'b0;
        chk("mrst_pc", pc, 32'h0);
        chk("mrst_retired", retired_count, 32'h0);
        chk("mrst_req", {31'd0, imem_bus.imem_req}, 32'd1);
        chk("mrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("mrst_instr", instr, 32'h0);
        chk("mrst_addr", imem_bus.imem_addr, 32'h0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
